ghost_mode_scheduler: RTL

//  Sequences the global ghost behaviour mode over a level: alternating SCATTER/CHASE waves, then permanent CHASE.
//  A FRIGHTENED override is triggered by power pellets; it pauses the wave timer and tracks which ghosts are still frightened.

---
 rtl/ghost_mode_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ghost_mode_scheduler.sv
// rtl/ghost_mode_scheduler.sv - global ghost mode sequencer: SCATTER/CHASE waves with FRIGHTENED override
module ghost_mode_scheduler #(
    parameter int NUM_GHOSTS  = 4,
    parameter int SCATTER_SEC = 7,
    parameter int CHASE_SEC   = 20,
    parameter int FRIGHT_SEC  = 6,
    parameter int NUM_WAVES   = 4,
    parameter int CW          = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  one_hz_enable,
    input  logic                  level_start,
    input  logic                  power_pellet,
    input  logic [NUM_GHOSTS-1:0] ghost_eaten,
    output logic [1:0]            mode,
    output logic [NUM_GHOSTS-1:0] fright_mask,
    output logic                  fright_ending,
    output logic                  reverse,
    output logic [2:0]            wave
);

    // State encoding doubles as the mode output code.
    typedef enum logic [1:0] {
        S_SCATTER = 2'b00,
        S_CHASE   = 2'b01,
        S_FRIGHT  = 2'b10,
        S_IDLE    = 2'b11
    } state_t;

    localparam logic [CW-1:0] SCATTER_LAST = CW'(SCATTER_SEC - 1);
    localparam logic [CW-1:0] CHASE_LAST   = CW'(CHASE_SEC - 1);
    localparam logic [CW-1:0] FRIGHT_LAST  = CW'(FRIGHT_SEC - 1);
    localparam logic [CW-1:0] FRIGHT_WARN  = CW'(FRIGHT_SEC - 2);
    localparam logic [2:0]    WAVE_LAST    = 3'(NUM_WAVES - 1);

    state_t                state_q, state_d;
    state_t                saved_q, saved_d;
    logic [CW-1:0]         phase_q, phase_d;
    logic [CW-1:0]         fcnt_q, fcnt_d;
    logic [NUM_GHOSTS-1:0] mask_q, mask_d;
    logic [NUM_GHOSTS-1:0] mask_left;
    logic                  rev_q, rev_d;
    logic [2:0]            wave_q, wave_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            saved_q <= S_SCATTER;
            phase_q <= '0;
            fcnt_q  <= '0;
            mask_q  <= '0;
            rev_q   <= 1'b0;
            wave_q  <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            phase_q <= phase_d;
            fcnt_q  <= fcnt_d;
            mask_q  <= mask_d;
            rev_q   <= rev_d;
            wave_q  <= wave_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        saved_d   = saved_q;
        phase_d   = phase_q;
        fcnt_d    = fcnt_q;
        mask_d    = mask_q;
        rev_d     = 1'b0;
        wave_d    = wave_q;
        mask_left = mask_q & ~ghost_eaten;

        if (level_start) begin
            state_d = S_SCATTER;
            wave_d  = '0;
            phase_d = '0;
            fcnt_d  = '0;
            mask_d  = '0;
        end else begin
            case (state_q)
                S_SCATTER, S_CHASE: begin
                    if (power_pellet) begin
                        // Wave timer is frozen, not cleared, so the phase resumes after fright.
                        state_d = S_FRIGHT;
                        saved_d = state_q;
                        fcnt_d  = '0;
                        mask_d  = '1;
                        rev_d   = 1'b1;
                    end else if (one_hz_enable) begin
                        if (state_q == S_SCATTER) begin
                            if (phase_q == SCATTER_LAST) begin
                                state_d = S_CHASE;
                                phase_d = '0;
                                rev_d   = 1'b1;
                            end else begin
                                phase_d = phase_q + 1'b1;
                            end
                        end else if (wave_q != WAVE_LAST) begin
                            if (phase_q == CHASE_LAST) begin
                                state_d = S_SCATTER;
                                wave_d  = wave_q + 3'd1;
                                phase_d = '0;
                                rev_d   = 1'b1;
                            end else begin
                                phase_d = phase_q + 1'b1;
                            end
                        end
                    end
                end
                S_FRIGHT: begin
                    if (power_pellet) begin
                        fcnt_d = '0;
                        mask_d = '1;
                        rev_d  = 1'b1;
                    end else if ((one_hz_enable && fcnt_q == FRIGHT_LAST) || mask_left == '0) begin
                        state_d = saved_q;
                        fcnt_d  = '0;
                        mask_d  = '0;
                    end else begin
                        mask_d = mask_left;
                        if (one_hz_enable) begin
                            fcnt_d = fcnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mode          = state_q;
    assign fright_mask   = mask_q;
    assign fright_ending = (state_q == S_FRIGHT) && (fcnt_q >= FRIGHT_WARN);
    assign reverse       = rev_q;
    assign wave          = wave_q;

endmodule
